quadrilatero_row_sequencer: RTL and testbench

//  Upstream stage of the quadrilatero OBI bridge. Turns one strided matrix-row transfer command into

---
 rtl/quadrilatero_row_sequencer.sv | 156 +++++++++++++++
 tb/tb_quadrilatero_row_sequencer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/quadrilatero_row_sequencer.sv
// Row sequencer feeding the quadrilatero OBI bridge: one strided command becomes one bus beat per row,
// with loads returned on a ready/valid stream and stores drawn from one. One beat in flight at a time.
module quadrilatero_row_sequencer #(
   parameter int BUS_WIDTH = 128,
   parameter int MAX_ROWS  = 16,
   parameter int OFF_BITS  = $clog2(BUS_WIDTH/8)
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  logic                          cmd_valid_i,
   output logic                          cmd_ready_o,
   input  logic                          cmd_we_i,
   input  logic [31:0]                   cmd_addr_i,
   input  logic [31:0]                   cmd_stride_i,
   input  logic [$clog2(MAX_ROWS+1)-1:0] cmd_rows_i,
   input  logic                          wdata_valid_i,
   output logic                          wdata_ready_o,
   input  logic [BUS_WIDTH-1:0]          wdata_i,
   output logic                          rdata_valid_o,
   input  logic                          rdata_ready_i,
   output logic [BUS_WIDTH-1:0]          rdata_o,
   output logic                          rdata_last_o,
   output logic                          done_o,
   output logic                          mem_req_o,
   output logic                          mem_we_o,
   output logic [BUS_WIDTH/8-1:0]        mem_be_o,
   output logic [31:0]                   mem_addr_o,
   output logic [BUS_WIDTH-1:0]          mem_wdata_o,
   input  logic                          mem_gnt_i,
   input  logic                          mem_rvalid_i,
   input  logic [BUS_WIDTH-1:0]          mem_rdata_i
);

   localparam int RW = $clog2(MAX_ROWS+1);

   typedef enum logic [2:0] {IDLE, WDATA, REQ, RSP, OUT} state_e;

   state_e               state_q;
   logic                 we_q;
   logic [31:0]          cur_addr_q;
   logic [31:0]          stride_q;
   logic [RW-1:0]        rows_q;
   logic [RW-1:0]        row_cnt_q;
   logic [BUS_WIDTH-1:0] wbuf_q;
   logic [BUS_WIDTH-1:0] rbuf_q;
   logic                 mem_req_q;
   logic                 wdata_ready_q;
   logic                 rdata_valid_q;
   logic                 rdata_last_q;
   logic                 done_q;
   logic                 last_row;
   logic                 row_done;

   assign last_row = (row_cnt_q == rows_q - RW'(1));
   // A row retires on the store response or when the load beat leaves the read stream.
   assign row_done = ((state_q == RSP) && mem_rvalid_i && we_q) ||
                     ((state_q == OUT) && rdata_ready_i);

   // The done cycle is kept closed so a new command always starts after the pulse.
   assign cmd_ready_o   = (state_q == IDLE) && !done_q;
   assign wdata_ready_o = wdata_ready_q;
   assign rdata_valid_o = rdata_valid_q;
   assign rdata_o       = rbuf_q;
   assign rdata_last_o  = rdata_last_q;
   assign done_o        = done_q;
   assign mem_req_o     = mem_req_q;
   assign mem_we_o      = we_q;
   assign mem_be_o      = '1;
   assign mem_addr_o    = {cur_addr_q[31:OFF_BITS], {OFF_BITS{1'b0}}};
   assign mem_wdata_o   = wbuf_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q       <= IDLE;
         we_q          <= 1'b0;
         cur_addr_q    <= '0;
         stride_q      <= '0;
         rows_q        <= '0;
         row_cnt_q     <= '0;
         wbuf_q        <= '0;
         rbuf_q        <= '0;
         mem_req_q     <= 1'b0;
         wdata_ready_q <= 1'b0;
         rdata_valid_q <= 1'b0;
         rdata_last_q  <= 1'b0;
         done_q        <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (cmd_valid_i && cmd_ready_o) begin
                  we_q       <= cmd_we_i;
                  cur_addr_q <= cmd_addr_i;
                  stride_q   <= cmd_stride_i;
                  rows_q     <= cmd_rows_i;
                  row_cnt_q  <= '0;
                  if (cmd_rows_i == '0) begin
                     done_q <= 1'b1;
                  end else if (cmd_we_i) begin
                     state_q       <= WDATA;
                     wdata_ready_q <= 1'b1;
                  end else begin
                     state_q   <= REQ;
                     mem_req_q <= 1'b1;
                  end
               end
            end
            WDATA: begin
               if (wdata_valid_i) begin
                  wbuf_q        <= wdata_i;
                  wdata_ready_q <= 1'b0;
                  mem_req_q     <= 1'b1;
                  state_q       <= REQ;
               end
            end
            REQ: begin
               if (mem_gnt_i) begin
                  mem_req_q <= 1'b0;
                  state_q   <= RSP;
               end
            end
            RSP: begin
               if (mem_rvalid_i && !we_q) begin
                  rbuf_q        <= mem_rdata_i;
                  rdata_valid_q <= 1'b1;
                  rdata_last_q  <= last_row;
                  state_q       <= OUT;
               end
            end
            OUT: begin
               if (rdata_ready_i) begin
                  rdata_valid_q <= 1'b0;
                  rdata_last_q  <= 1'b0;
               end
            end
            default: state_q <= IDLE;
         endcase

         if (row_done) begin
            row_cnt_q  <= row_cnt_q + RW'(1);
            cur_addr_q <= cur_addr_q + stride_q;
            if (last_row) begin
               state_q <= IDLE;
               done_q  <= 1'b1;
            end else if (we_q) begin
               state_q       <= WDATA;
               wdata_ready_q <= 1'b1;
            end else begin
               state_q   <= REQ;
               mem_req_q <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_quadrilatero_row_sequencer.sv
// Randomized bench for quadrilatero_row_sequencer: a bus/stream responder plus a row-level reference model.
module tb_quadrilatero_row_sequencer;

   localparam int BW = 128;
   localparam int NB = BW/8;
   localparam int RW = 5;

   logic          clk_i = 1'b0;
   logic          rst_ni;
   logic          cmd_valid_i;
   logic          cmd_ready_o;
   logic          cmd_we_i;
   logic [31:0]   cmd_addr_i;
   logic [31:0]   cmd_stride_i;
   logic [RW-1:0] cmd_rows_i;
   logic          wdata_valid_i;
   logic          wdata_ready_o;
   logic [BW-1:0] wdata_i;
   logic          rdata_valid_o;
   logic          rdata_ready_i;
   logic [BW-1:0] rdata_o;
   logic          rdata_last_o;
   logic          done_o;
   logic          mem_req_o;
   logic          mem_we_o;
   logic [NB-1:0] mem_be_o;
   logic [31:0]   mem_addr_o;
   logic [BW-1:0] mem_wdata_o;
   logic          mem_gnt_i;
   logic          mem_rvalid_i;
   logic [BW-1:0] mem_rdata_i;

   int n_vec = 0;
   int n_err = 0;

   quadrilatero_row_sequencer dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
      .cmd_addr_i(cmd_addr_i), .cmd_stride_i(cmd_stride_i), .cmd_rows_i(cmd_rows_i),
      .wdata_valid_i(wdata_valid_i), .wdata_ready_o(wdata_ready_o), .wdata_i(wdata_i),
      .rdata_valid_o(rdata_valid_o), .rdata_ready_i(rdata_ready_i), .rdata_o(rdata_o),
      .rdata_last_o(rdata_last_o), .done_o(done_o),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_addr_o(mem_addr_o),
      .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
      .mem_rdata_i(mem_rdata_i)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [BW-1:0] rand_beat();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic idle_inputs();
      cmd_valid_i   = 1'b0;
      cmd_we_i      = 1'b0;
      cmd_addr_i    = '0;
      cmd_stride_i  = '0;
      cmd_rows_i    = '0;
      wdata_valid_i = 1'b0;
      wdata_i       = '0;
      rdata_ready_i = 1'b0;
      mem_gnt_i     = 1'b0;
      mem_rvalid_i  = 1'b0;
      mem_rdata_i   = '0;
   endtask

   // mode 0: zero-wait bus and streams; mode 1: gnt held off 5 cycles, rdata_ready 3 cycles; mode 2: random
   task automatic run_cmd(input logic we, input logic [31:0] addr, input logic [31:0] stride,
                          input int rows, input int mode);
      logic [BW-1:0] wq[16];
      logic [BW-1:0] rq[$];
      logic [31:0]   exp_addr;
      int grants = 0, rsps = 0, consumed = 0, next_w = 0;
      int req_age = 0, out_age = 0, rsp_wait = 0, cyc = 0, waited = 0;
      bit pending = 1'b0, finished = 1'b0;

      for (int i = 0; i < 16; i++) wq[i] = rand_beat();
      while (!cmd_ready_o && waited < 50) begin
         @(negedge clk_i);
         waited++;
      end
      if (!cmd_ready_o) begin
         chk("cmd_ready_timeout", BW'(cmd_ready_o), BW'(1));
         return;
      end
      cmd_valid_i  = 1'b1;
      cmd_we_i     = we;
      cmd_addr_i   = addr;
      cmd_stride_i = stride;
      cmd_rows_i   = RW'(rows);
      @(negedge clk_i);
      // Scramble the command fields so only latched values can produce correct beats.
      cmd_valid_i  = 1'b0;
      cmd_we_i     = ~we;
      cmd_addr_i   = $urandom;
      cmd_stride_i = $urandom;
      cmd_rows_i   = RW'($urandom_range(0, 16));
      cyc = 1;

      while (!finished) begin
         if (mem_req_o) begin
            if (grants >= rows) chk("extra_req", BW'(mem_req_o), BW'(0));
            else begin
               exp_addr = (addr + 32'(grants) * stride) & 32'hFFFF_FFF0;
               chk("mem_addr", BW'(mem_addr_o), BW'(exp_addr));
               chk("mem_we", BW'(mem_we_o), BW'(we));
               chk("mem_be", BW'(mem_be_o), BW'({NB{1'b1}}));
               if (we) chk("mem_wdata", mem_wdata_o, wq[grants]);
            end
         end
         if (rdata_valid_o) begin
            if (rq.size() == 0) chk("spurious_rdata", BW'(rdata_valid_o), BW'(0));
            else begin
               chk("rdata", rdata_o, rq[0]);
               chk("rdata_last", BW'(rdata_last_o), BW'(consumed == rows - 1));
            end
         end
         if (done_o) begin
            chk("n_grants", BW'(grants), BW'(rows));
            chk("n_rsp", BW'(rsps), BW'(rows));
            if (we) chk("n_wbeats", BW'(next_w), BW'(rows));
            else    chk("n_rbeats", BW'(consumed), BW'(rows));
            if (mode == 0) chk("done_cycle", BW'(cyc), BW'(1 + 3 * rows));
            finished = 1'b1;
         end else if (cyc > 1500) begin
            chk("done_timeout", BW'(done_o), BW'(1));
            finished = 1'b1;
         end

         if (!finished) begin
            mem_gnt_i = 1'b0;
            if (mem_req_o) begin
               case (mode)
                  0:       mem_gnt_i = 1'b1;
                  1:       mem_gnt_i = (req_age >= 5);
                  default: mem_gnt_i = ($urandom_range(0, 2) == 0);
               endcase
               req_age++;
            end else if (mode == 2) mem_gnt_i = ($urandom_range(0, 4) == 0);

            mem_rvalid_i = 1'b0;
            mem_rdata_i  = rand_beat();
            if (pending) begin
               if (rsp_wait == 0) begin
                  mem_rvalid_i = 1'b1;
                  pending      = 1'b0;
                  rsps++;
                  if (!we) rq.push_back(mem_rdata_i);
               end else rsp_wait--;
            end else if (mode == 2) mem_rvalid_i = ($urandom_range(0, 4) == 0);

            if (mem_req_o && mem_gnt_i) begin
               grants++;
               pending  = 1'b1;
               req_age  = 0;
               rsp_wait = (mode == 2) ? $urandom_range(0, 3) : 0;
            end

            rdata_ready_i = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (rdata_valid_o) begin
               case (mode)
                  0:       rdata_ready_i = 1'b1;
                  1:       rdata_ready_i = (out_age >= 3);
                  default: ;
               endcase
               out_age++;
               if (rdata_ready_i && rq.size() > 0) begin
                  consumed++;
                  out_age = 0;
                  void'(rq.pop_front());
               end
            end

            wdata_valid_i = (next_w < rows) && (mode != 2 || $urandom_range(0, 1) == 1);
            wdata_i       = wq[(next_w < 16) ? next_w : 15];
            if (wdata_valid_i && wdata_ready_o) next_w++;

            @(negedge clk_i);
            cyc++;
         end
      end
      idle_inputs();
      @(negedge clk_i);
      chk("done_pulse", BW'(done_o), BW'(0));
      chk("cmd_ready_after", BW'(cmd_ready_o), BW'(1));
   endtask

   task automatic reset_mid();
      idle_inputs();
      cmd_valid_i  = 1'b1;
      cmd_addr_i   = 32'h5000;
      cmd_stride_i = 32'h40;
      cmd_rows_i   = RW'(3);
      @(negedge clk_i);
      cmd_valid_i = 1'b0;
      chk("rm_req", BW'(mem_req_o), BW'(1));
      mem_gnt_i = 1'b1;
      @(negedge clk_i);
      mem_gnt_i = 1'b0;
      chk("rm_rsp_req_low", BW'(mem_req_o), BW'(0));
      rst_ni = 1'b0;
      #1;
      chk("rm_outs", BW'({mem_req_o, wdata_ready_o, rdata_valid_o, done_o, mem_we_o}), BW'(0));
      chk("rm_addr", BW'(mem_addr_o), BW'(0));
      @(negedge clk_i);
      rst_ni       = 1'b1;
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = rand_beat();
      @(negedge clk_i);
      mem_rvalid_i = 1'b0;
      chk("rm_cmd_ready", BW'(cmd_ready_o), BW'(1));
      for (int i = 0; i < 4; i++) begin
         chk("rm_quiet", BW'({done_o, mem_req_o, rdata_valid_o}), BW'(0));
         @(negedge clk_i);
      end
   endtask

   initial begin
      idle_inputs();
      rst_ni = 1'b0;
      repeat (3) @(negedge clk_i);
      chk("rst_outs", BW'({mem_req_o, wdata_ready_o, rdata_valid_o, done_o}), BW'(0));
      chk("rst_addr", BW'(mem_addr_o), BW'(0));
      rst_ni = 1'b1;
      @(negedge clk_i);
      chk("rst_cmd_ready", BW'(cmd_ready_o), BW'(1));

      run_cmd(1'b0, 32'h1000,     32'h40, 4, 0);
      run_cmd(1'b1, 32'h2008,     32'h10, 2, 0);
      run_cmd(1'b0, 32'h3000,     32'h20, 3, 1);
      run_cmd(1'b1, 32'h3800,     32'h20, 2, 1);
      run_cmd(1'b0, 32'h4000,     32'h10, 0, 0);
      run_cmd(1'b1, 32'h4000,     32'h10, 0, 0);
      run_cmd(1'b0, 32'hFFFFFFF0, 32'h10, 2, 0);
      run_cmd(1'b1, 32'hFFFFFFF4, 32'h14, 3, 2);
      run_cmd(1'b0, 32'h0000_0007, 32'h0000_0009, 16, 2);
      reset_mid();
      for (int n = 0; n < 60; n++) begin
         run_cmd(1'($urandom_range(0, 1)), $urandom,
                 ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 255)),
                 $urandom_range(0, 16), 2);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
